// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: byte-enable patterns,
// FSM state encoding and load-extension helpers.
package mem_access_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [3:0] MEM_SEL_BYTE0 = 4'b0001;
    localparam logic [3:0] MEM_SEL_BYTE1 = 4'b0010;
    localparam logic [3:0] MEM_SEL_BYTE2 = 4'b0100;
    localparam logic [3:0] MEM_SEL_BYTE3 = 4'b1000;
    localparam logic [3:0] MEM_SEL_HALF0 = 4'b0011;
    localparam logic [3:0] MEM_SEL_HALF1 = 4'b1100;
    localparam logic [3:0] MEM_SEL_WORD  = 4'b1111;

    function automatic logic [31:0] extendByte(input logic [7:0] b, input logic signExt);
        return {{24{signExt & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extendHalf(input logic [15:0] h, input logic signExt);
        return {{16{signExt & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side, data-RAM and write-back signals of the memory-access stage.
// The stage itself uses the master view; its environment uses the slave view.
interface mem_access_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_read_flag;
    logic                  mem_write_flag;
    logic                  mem_sign_ext_flag;
    logic [3:0]            mem_sel;
    logic [DATA_W-1:0]     mem_write_data;
    logic [DATA_W-1:0]     result;
    logic                  reg_write_en;
    logic [REG_ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0]     current_pc_addr;

    logic                  ram_req;
    logic [3:0]            ram_we;
    logic [DATA_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic                  ram_ack;
    logic [DATA_W-1:0]     ram_rdata;

    logic                  wb_valid;
    logic [DATA_W-1:0]     wb_result;
    logic                  wb_reg_write_en;
    logic [REG_ADDR_W-1:0] wb_reg_write_addr;
    logic [DATA_W-1:0]     wb_pc_addr;
    logic                  mem_busy;

    modport master (
        input  in_valid, mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
               mem_write_data, result, reg_write_en, reg_write_addr, current_pc_addr,
               ram_ack, ram_rdata,
        output in_ready, ram_req, ram_we, ram_addr, ram_wdata,
               wb_valid, wb_result, wb_reg_write_en, wb_reg_write_addr, wb_pc_addr, mem_busy
    );

    modport slave (
        output in_valid, mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
               mem_write_data, result, reg_write_en, reg_write_addr, current_pc_addr,
               ram_ack, ram_rdata,
        input  in_ready, ram_req, ram_we, ram_addr, ram_wdata,
               wb_valid, wb_result, wb_reg_write_en, wb_reg_write_addr, wb_pc_addr, mem_busy
    );

endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of a RAM word
// and zero- or sign-extends it. Unknown lane patterns pass the word through raw.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  sel,
    input  logic        sign_ext,
    output logic [31:0] aligned_word
);

    always_comb begin
        aligned_word = rdata;
        case (sel)
            MEM_SEL_BYTE0: aligned_word = extendByte(rdata[7:0],   sign_ext);
            MEM_SEL_BYTE1: aligned_word = extendByte(rdata[15:8],  sign_ext);
            MEM_SEL_BYTE2: aligned_word = extendByte(rdata[23:16], sign_ext);
            MEM_SEL_BYTE3: aligned_word = extendByte(rdata[31:24], sign_ext);
            MEM_SEL_HALF0: aligned_word = extendHalf(rdata[15:0],  sign_ext);
            MEM_SEL_HALF1: aligned_word = extendHalf(rdata[31:16], sign_ext);
            default:       aligned_word = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs one req/ack RAM transaction per load/store,
// passes other instructions straight to the write-back register.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.master bus
);

    state_t r_state;
    state_t w_nextState;
    logic   w_accept;
    logic   w_ackDone;
    logic   w_isMem;
    logic   w_isStore;

    logic                  r_isLoad;
    logic                  r_signExt;
    logic [3:0]            r_sel;
    logic [DATA_W-1:0]     r_result;
    logic                  r_regWriteEn;
    logic [REG_ADDR_W-1:0] r_regWriteAddr;
    logic [DATA_W-1:0]     r_pc;

    logic [DATA_W-1:0]     r_ramAddr;
    logic [DATA_W-1:0]     r_ramWdata;
    logic [3:0]            r_ramWe;

    logic                  r_wbValid;
    logic [DATA_W-1:0]     r_wbResult;
    logic                  r_wbRegWriteEn;
    logic [REG_ADDR_W-1:0] r_wbRegWriteAddr;
    logic [DATA_W-1:0]     r_wbPc;

    logic [DATA_W-1:0]     w_storeData;
    logic [DATA_W-1:0]     w_loadWord;

    assign w_isMem   = bus.mem_read_flag | bus.mem_write_flag;
    assign w_isStore = bus.mem_write_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Acks outside REQ and requests inside REQ are simply never looked at.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_ackDone   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.in_valid;
                if (bus.in_valid && w_isMem) begin
                    w_nextState = ST_REQ;
                end
            end
            ST_REQ: begin
                w_ackDone = bus.ram_ack;
                if (bus.ram_ack) begin
                    w_nextState = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_storeData = bus.mem_write_data;
        case (bus.mem_sel)
            MEM_SEL_BYTE0, MEM_SEL_BYTE1, MEM_SEL_BYTE2, MEM_SEL_BYTE3:
                w_storeData = {4{bus.mem_write_data[7:0]}};
            MEM_SEL_HALF0, MEM_SEL_HALF1:
                w_storeData = {2{bus.mem_write_data[15:0]}};
            default:
                w_storeData = bus.mem_write_data;
        endcase
    end

    // Everything the RAM port and write-back need is captured at accept, so
    // execute's inputs are free to change while the access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_isLoad       <= 1'b0;
            r_signExt      <= 1'b0;
            r_sel          <= '0;
            r_result       <= '0;
            r_regWriteEn   <= 1'b0;
            r_regWriteAddr <= '0;
            r_pc           <= '0;
            r_ramAddr      <= '0;
            r_ramWdata     <= '0;
            r_ramWe        <= '0;
        end else if (w_accept && w_isMem) begin
            r_isLoad       <= ~w_isStore;
            r_signExt      <= bus.mem_sign_ext_flag;
            r_sel          <= bus.mem_sel;
            r_result       <= bus.result;
            r_regWriteEn   <= bus.reg_write_en;
            r_regWriteAddr <= bus.reg_write_addr;
            r_pc           <= bus.current_pc_addr;
            r_ramAddr      <= {bus.result[DATA_W-1:2], 2'b00};
            r_ramWdata     <= w_storeData;
            r_ramWe        <= w_isStore ? bus.mem_sel : 4'b0000;
        end else if (w_ackDone) begin
            r_ramWe        <= 4'b0000;
        end
    end

    load_align u_loadAlign (
        .rdata        (bus.ram_rdata),
        .sel          (r_sel),
        .sign_ext     (r_signExt),
        .aligned_word (w_loadWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbValid        <= 1'b0;
            r_wbResult       <= '0;
            r_wbRegWriteEn   <= 1'b0;
            r_wbRegWriteAddr <= '0;
            r_wbPc           <= '0;
        end else begin
            r_wbValid <= 1'b0;
            if (w_accept && !w_isMem) begin
                r_wbValid        <= 1'b1;
                r_wbResult       <= bus.result;
                r_wbRegWriteEn   <= bus.reg_write_en;
                r_wbRegWriteAddr <= bus.reg_write_addr;
                r_wbPc           <= bus.current_pc_addr;
            end else if (w_ackDone) begin
                r_wbValid        <= 1'b1;
                r_wbResult       <= r_isLoad ? w_loadWord : r_result;
                r_wbRegWriteEn   <= r_isLoad & r_regWriteEn;
                r_wbRegWriteAddr <= r_regWriteAddr;
                r_wbPc           <= r_pc;
            end
        end
    end

    assign bus.in_ready          = (r_state == ST_IDLE);
    assign bus.ram_req           = (r_state == ST_REQ);
    assign bus.mem_busy          = (r_state == ST_REQ);
    assign bus.ram_addr          = r_ramAddr;
    assign bus.ram_wdata         = r_ramWdata;
    assign bus.ram_we            = r_ramWe;
    assign bus.wb_valid          = r_wbValid;
    assign bus.wb_result         = r_wbResult;
    assign bus.wb_reg_write_en   = r_wbRegWriteEn;
    assign bus.wb_reg_write_addr = r_wbRegWriteAddr;
    assign bus.wb_pc_addr        = r_wbPc;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios then random
// loads/stores/ALU ops against a lane-arithmetic reference model.
module tb_mem_access;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        sx;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] res;
        logic        rwe;
        logic [4:0]  rad;
        logic [31:0] pc;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [31:0] lastRes = 32'd0;

    mem_access_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    mem_access #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Byte/half loads: shift the addressed lane down, mask, then extend.
    function automatic logic [31:0] modelLoad(input logic [3:0] sel, input logic [31:0] rdata, input logic sx);
        int          shift;
        int          width;
        logic [31:0] mask;
        logic [31:0] v;
        shift = 0;
        width = 32;
        if ($countones(sel) == 1) begin
            width = 8;
            for (int k = 0; k < 4; k++) if (sel[k]) shift = 8 * k;
        end else if (sel == 4'b0011) begin
            width = 16;
        end else if (sel == 4'b1100) begin
            width = 16;
            shift = 16;
        end
        if (width == 32) return rdata;
        mask = (32'd1 << width) - 32'd1;
        v = (rdata >> shift) & mask;
        if (sx && v[width-1]) v = v | ~mask;
        return v;
    endfunction

    // Each RAM byte k repeats operand byte (k mod access size).
    function automatic logic [31:0] modelStore(input logic [3:0] sel, input logic [31:0] wd);
        int          n;
        logic [31:0] out;
        if ($countones(sel) == 1) n = 1;
        else if (sel == 4'b0011 || sel == 4'b1100) n = 2;
        else return wd;
        for (int k = 0; k < 4; k++) out[8*k +: 8] = wd[8*(k % n) +: 8];
        return out;
    endfunction

    function automatic op_t makeOp(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                                   input logic [31:0] wd, input logic [31:0] res, input logic rwe,
                                   input logic [4:0] rad, input logic [31:0] pc);
        op_t o;
        o.rd = rd; o.wr = wr; o.sx = sx; o.sel = sel; o.wd = wd;
        o.res = res; o.rwe = rwe; o.rad = rad; o.pc = pc;
        return o;
    endfunction

    function automatic op_t randOp();
        op_t o;
        logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        int kind;
        kind = int'($urandom_range(0, 3));
        o.rd  = (kind == 1 || kind == 3);
        o.wr  = (kind == 2 || kind == 3);
        o.sx  = 1'($urandom_range(0, 1));
        o.sel = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 6)];
        o.wd  = $urandom;
        o.res = $urandom;
        o.rwe = 1'($urandom_range(0, 1));
        o.rad = 5'($urandom_range(0, 31));
        o.pc  = {$urandom, 2'b00} [31:0];
        return o;
    endfunction

    task automatic drive(input op_t op);
        bus.mem_read_flag     = op.rd;
        bus.mem_write_flag    = op.wr;
        bus.mem_sign_ext_flag = op.sx;
        bus.mem_sel           = op.sel;
        bus.mem_write_data    = op.wd;
        bus.result            = op.res;
        bus.reg_write_en      = op.rwe;
        bus.reg_write_addr    = op.rad;
        bus.current_pc_addr   = op.pc;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkWb(input string tag, input op_t op, input logic [31:0] rdata);
        logic [31:0] expRes;
        logic        expRwe;
        expRes = (op.rd && !op.wr) ? modelLoad(op.sel, rdata, op.sx) : op.res;
        expRwe = op.wr ? 1'b0 : op.rwe;
        checkOutput({tag, "_wbValid"}, 32'(bus.wb_valid), 32'd1);
        checkOutput({tag, "_wbResult"}, bus.wb_result, expRes);
        checkOutput({tag, "_wbRwe"}, 32'(bus.wb_reg_write_en), 32'(expRwe));
        checkOutput({tag, "_wbRad"}, 32'(bus.wb_reg_write_addr), 32'(op.rad));
        checkOutput({tag, "_wbPc"}, bus.wb_pc_addr, op.pc);
        lastRes = expRes;
    endtask

    // Presents op; during a RAM access, stallOp sits on the (ignored) inputs.
    task automatic applyStimulus(input string tag, input op_t op, input int ackDelay,
                                 input logic [31:0] rdata, input op_t stallOp);
        logic [31:0] expWe;
        checkOutput({tag, "_inReady"}, 32'(bus.in_ready), 32'd1);
        drive(op);
        bus.in_valid = 1'b1;
        stepCycle();
        if (!(op.rd || op.wr)) begin
            checkOutput({tag, "_noReq"}, 32'(bus.ram_req), 32'd0);
            checkWb(tag, op, 32'd0);
        end else begin
            expWe = op.wr ? 32'(op.sel) : 32'd0;
            drive(stallOp);
            for (int c = 0; c <= ackDelay; c++) begin
                checkOutput({tag, "_req"}, 32'(bus.ram_req), 32'd1);
                checkOutput({tag, "_busy"}, 32'(bus.mem_busy), 32'd1);
                checkOutput({tag, "_stallReady"}, 32'(bus.in_ready), 32'd0);
                checkOutput({tag, "_stallWb"}, 32'(bus.wb_valid), 32'd0);
                checkOutput({tag, "_addr"}, bus.ram_addr, {op.res[31:2], 2'b00});
                checkOutput({tag, "_we"}, 32'(bus.ram_we), expWe);
                if (op.wr) checkOutput({tag, "_wdata"}, bus.ram_wdata, modelStore(op.sel, op.wd));
                if (c == ackDelay) begin
                    bus.ram_ack   = 1'b1;
                    bus.ram_rdata = rdata;
                end else begin
                    bus.ram_rdata = $urandom;
                end
                stepCycle();
            end
            bus.ram_ack = 1'b0;
            checkOutput({tag, "_reqDrop"}, 32'(bus.ram_req), 32'd0);
            checkOutput({tag, "_readyBack"}, 32'(bus.in_ready), 32'd1);
            checkOutput({tag, "_busyDrop"}, 32'(bus.mem_busy), 32'd0);
            checkWb(tag, op, rdata);
        end
    endtask

    task automatic idle(input string tag);
        bus.in_valid = 1'b0;
        stepCycle();
        checkOutput({tag, "_pulse"}, 32'(bus.wb_valid), 32'd0);
        checkOutput({tag, "_hold"}, bus.wb_result, lastRes);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, 32'(bus.ram_req), 32'd0);
        checkOutput({tag, "_we"}, 32'(bus.ram_we), 32'd0);
        checkOutput({tag, "_addr"}, bus.ram_addr, 32'd0);
        checkOutput({tag, "_wdata"}, bus.ram_wdata, 32'd0);
        checkOutput({tag, "_wbValid"}, 32'(bus.wb_valid), 32'd0);
        checkOutput({tag, "_wbResult"}, bus.wb_result, 32'd0);
        checkOutput({tag, "_wbRwe"}, 32'(bus.wb_reg_write_en), 32'd0);
        checkOutput({tag, "_wbRad"}, 32'(bus.wb_reg_write_addr), 32'd0);
        checkOutput({tag, "_wbPc"}, bus.wb_pc_addr, 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.mem_busy), 32'd0);
    endtask

    initial begin
        op_t opA;
        op_t opB;
        op_t opC;
        op_t junk;
        junk = makeOp(1'b1, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b1, 5'd31, 32'hFFFF_FFF0);
        bus.in_valid  = 1'b0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 32'd0;
        drive(junk);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetValues("reset");
        checkOutput("reset_inReady", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        $display("[TB] ADDU pass-through");
        opA = makeOp(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'h0000_1234, 1'b1, 5'd5, 32'h0000_0400);
        applyStimulus("addu", opA, 0, 32'd0, junk);
        idle("addu_after");

        $display("[TB] LB sign-extend, ack after 3 waits");
        opA = makeOp(1'b1, 1'b0, 1'b1, 4'b0100, 32'd0, 32'h0000_0102, 1'b1, 5'd7, 32'h0000_0404);
        applyStimulus("lb", opA, 3, 32'h0080_0000, junk);
        idle("lb_after");

        $display("[TB] LHU, ack in first REQ cycle");
        opA = makeOp(1'b1, 1'b0, 1'b0, 4'b1100, 32'd0, 32'h0000_0202, 1'b1, 5'd8, 32'h0000_0408);
        applyStimulus("lhu", opA, 0, 32'h8001_0000, junk);
        idle("lhu_after");

        $display("[TB] SB lane 1");
        opA = makeOp(1'b0, 1'b1, 1'b0, 4'b0010, 32'h1234_56AB, 32'h0000_0301, 1'b1, 5'd9, 32'h0000_040C);
        applyStimulus("sb", opA, 1, 32'h5555_5555, junk);
        idle("sb_after");

        $display("[TB] back-to-back ADDU, LW, ADDU");
        opA = makeOp(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'h0000_0011, 1'b1, 5'd1, 32'h0000_0500);
        opB = makeOp(1'b1, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h0000_0600, 1'b1, 5'd2, 32'h0000_0504);
        opC = makeOp(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'h0000_0033, 1'b1, 5'd3, 32'h0000_0508);
        applyStimulus("b2b_addu1", opA, 0, 32'd0, junk);
        applyStimulus("b2b_lw", opB, 2, 32'hCAFE_F00D, opC);
        applyStimulus("b2b_addu2", opC, 0, 32'd0, junk);
        idle("b2b_after");

        $display("[TB] async reset during REQ");
        opA = makeOp(1'b1, 1'b0, 1'b0, 4'b0001, 32'd0, 32'h0000_0700, 1'b1, 5'd4, 32'h0000_0600);
        drive(opA);
        bus.in_valid = 1'b1;
        stepCycle();
        bus.in_valid = 1'b0;
        checkOutput("rstmid_req", 32'(bus.ram_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkResetValues("rstmid");
        @(negedge clk);
        rst = 1'b0;
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h0000_00AA;
        stepCycle();
        bus.ram_ack = 1'b0;
        checkOutput("spurious_wbValid", 32'(bus.wb_valid), 32'd0);
        checkOutput("spurious_req", 32'(bus.ram_req), 32'd0);
        checkOutput("spurious_inReady", 32'(bus.in_ready), 32'd1);
        lastRes = 32'd0;
        idle("spurious_after");

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus("rand", randOp(), int'($urandom_range(0, 3)), $urandom, randOp());
            if ($urandom_range(0, 2) == 0) idle("rand_idle");
        end
        idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage CPU core, directly downstream of the execute stage. It takes the ALU result and the memory control bundle that execute forwards, and runs a req/ack transaction on the data-RAM port for loads and stores. It aligns and sign-extends load data, registers the write-back bundle, and back-pressures execute while an access is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.
- `REG_ADDR_W`, 5, register-file address width.

Ports. One clock; reset is asynchronous and active-high; clock port `clk`, reset port `rst`.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute presents an instruction.
- `in_ready`  out  1  stage can accept (high only in IDLE).
- `mem_read_flag`  in  1  load.
- `mem_write_flag`  in  1  store.
- `mem_sign_ext_flag`  in  1  sign-extend load data.
- `mem_sel`  in  4  byte enables, already shifted to the lane given by `result[1:0]`.
- `mem_write_data`  in  32  raw store operand (low byte/half/word).
- `result`  in  32  ALU result; also the effective address for memory ops.
- `reg_write_en`  in  1  write-back enable (execute already clears it for stores).
- `reg_write_addr`  in  5  destination register.
- `current_pc_addr`  in  32  PC of the instruction.
- `ram_req`  out  1  access request; held until ack.
- `ram_we`  out  4  byte write enables; 0 for loads.
- `ram_addr`  out  32  `{result[31:2],2'b00}`.
- `ram_wdata`  out  32  lane-replicated store data.
- `ram_ack`  in  1  one-cycle completion pulse.
- `ram_rdata`  in  32  read word, valid with `ram_ack`.
- `wb_valid`  out  1  one-cycle pulse per retired instruction.
- `wb_result`  out  32  value to write back.
- `wb_reg_write_en`  out  1  write-back enable.
- `wb_reg_write_addr`  out  5  destination.
- `wb_pc_addr`  out  32  PC, for debug trace.
- `mem_busy`  out  1  level; high while state is REQ (to hazard unit).

## Operation
FSM states are IDLE and REQ.
- **IDLE, accept (`in_valid`):**
  - Non-memory op: load the wb register with `result`, `reg_write_en` and `reg_write_addr`. Next cycle `wb_valid`=1. Stay in IDLE.
  - Load or store: latch address, `mem_sel`, flags and write-back fields. Go to REQ.
- **REQ:**
  - `ram_req`=1. `ram_addr`, `ram_we` and `ram_wdata` come from the latched fields and are stable until ack.
  - On `ram_ack`:
    - Load: `wb_result` = aligned `ram_rdata`.
    - Store: `wb_reg_write_en` is forced 0.
    - In both cases `wb_valid` goes high next cycle and the FSM returns to IDLE.
- **Store data replication:** `ram_we` = `mem_sel`.
  - Byte patterns (0001/0010/0100/1000): `{4{wd[7:0]}}`.
  - Half patterns (0011/1100): `{2{wd[15:0]}}`.
  - 1111: `wd`.
- **Load alignment:**
  - Byte lane k: `rdata[8k+7:8k]`.
  - 0011: `[15:0]`; 1100: `[31:16]`; 1111: full word.
  - Zero- or sign-extend to 32 bits according to `mem_sign_ext_flag`.
- **Illegal `mem_sel`** (0000, 0110, 0101, …): the access is issued unchanged. A load returns raw `ram_rdata`. Not flagged.
- If both read and write flags are set, the access is treated as a store.

## Timing
- Reset values: state IDLE, `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `wb_valid`=0, `wb_result`=0, `wb_reg_write_en`=0, `wb_reg_write_addr`=0, `wb_pc_addr`=0, `mem_busy`=0. `in_ready`=1 after reset deasserts.
- Non-memory op accepted at cycle N: `wb_valid` at N+1. Back-to-back accepts every cycle.
- Memory op accepted at N:
  - `ram_req` rises at N+1.
  - Ack sampled at cycle M ≥ N+1; an ack in the first REQ cycle is legal.
  - `ram_req` falls at M+1, `wb_valid` at M+1, `in_ready` back at M+1.
  - Minimum latency is 2 cycles.
- `ram_ack` while `ram_req`=0 is ignored.
- `in_ready`=0 in REQ. Execute must hold its inputs; `in_valid` in REQ is ignored.
- Reset mid-REQ: the transaction is abandoned and `wb_valid` is never pulsed for it. The RAM port must tolerate a dropped request.
- `wb_*` fields hold their values between pulses.

## Structure
- Add to the shared `bus.v`/`funct.v`-style header:
  - `MEM_SEL` pattern constants (BYTE0..3, HALF0, HALF1, WORD).
  - FSM state encodings.
- Sub-module `load_align`: purely combinational; inputs `rdata`, `sel`, `sign_ext`; output 32-bit word. Reused by a future uncached/MMIO path.
- Replication logic stays inline.

## Test plan
- ADDU pass-through: `result`=0x0000_1234, `reg_write_en`=1, addr 5 → next cycle `wb_valid`=1, `wb_result`=0x1234, no `ram_req`.
- LB sign-ext: addr 0x100 with `result[1:0]`=2, `mem_sel`=0100, `ram_rdata`=0x0080_0000, ack after 3 wait cycles → `wb_result`=0xFFFF_FF80. `ram_req` is high exactly 4 cycles and `in_ready` is low throughout.
- LHU: `mem_sel`=1100, `rdata`=0x8001_0000, ack in the first REQ cycle → `wb_result`=0x0000_8001, 2-cycle latency.
- SB: `mem_sel`=0010, `wd`=0x1234_56AB → `ram_we`=0010, `ram_wdata`=0xABAB_ABAB, `wb_reg_write_en`=0.
- Back-to-back: ADDU, LW, ADDU with `in_valid` held → LW stalls the second ADDU until the ack. `wb_valid` pulses in order with the correct PCs.
- Async reset asserted in REQ between clock edges → all outputs go to reset values immediately. A spurious ack afterwards produces no `wb_valid`.
